sram_ctrl_5: RTL and testbench



---
 rtl/sram_ctrl_5_if.sv | 33 +++
 rtl/sram_ctrl_5.sv | 121 ++++++++++++
 tb/tb_sram_ctrl_5.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_5_if.sv
// sram_ctrl_5 pipeline-side channels:
// write, read-request and read-response handshakes.
interface sram_ctrl_5_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24,
  parameter int GROUPS = 4
);
  logic              io_w_valid;
  logic              io_w_ready;
  logic [ADDR_W-1:0] io_w_addr;
  logic [DATA_W-1:0] io_w_data;
  logic [GROUPS-1:0] io_w_mask;
  logic              io_r_valid;
  logic              io_r_ready;
  logic [ADDR_W-1:0] io_r_addr;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic [DATA_W-1:0] io_resp_data;

  modport master (
    output io_w_valid, io_w_addr, io_w_data, io_w_mask,
    output io_r_valid, io_r_addr, io_resp_ready,
    input  io_w_ready, io_r_ready,
    input  io_resp_valid, io_resp_data
  );

  modport slave (
    input  io_w_valid, io_w_addr, io_w_data, io_w_mask,
    input  io_r_valid, io_r_addr, io_resp_ready,
    output io_w_ready, io_r_ready,
    output io_resp_valid, io_resp_data
  );
endinterface

// File: rtl/sram_ctrl_5.sv
// sram_ctrl_5: client controller for a 64x24 masked 1R1W SRAM macro.
// Zero-fills the array after reset, then serves writes and buffered reads.
module sram_ctrl_5 #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 24,
  parameter int GROUPS     = 4,
  parameter int RESP_DEPTH = 2,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  sram_ctrl_5_if.slave      io,
  output logic              io_init_done,
  output logic              sram_W0_en,
  output logic [ADDR_W-1:0] sram_W0_addr,
  output logic [DATA_W-1:0] sram_W0_data,
  output logic [GROUPS-1:0] sram_W0_mask,
  output logic              sram_R0_en,
  output logic [ADDR_W-1:0] sram_R0_addr,
  input  logic [DATA_W-1:0] sram_R0_data
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo [RESP_DEPTH];

  logic             in_init;
  logic             in_run;
  logic             init_last;
  logic             push;
  logic             pop;
  logic             r_fire;
  logic [CNT_W:0]   occ;

  function automatic logic [PTR_W-1:0] ptr_nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every output is gated by reset so it is quiet for the whole reset window.
  assign in_init   = reset & (state == ST_INIT);
  assign in_run    = reset & (state == ST_RUN);
  assign init_last = (init_cnt == '1) | !INIT_EN;

  assign push = inflight;
  assign pop  = io.io_resp_valid & io.io_resp_ready;

  // Occupancy counts the read still in the macro so a push always has room.
  assign occ = {1'b0, count}
             + {{CNT_W{1'b0}}, inflight}
             - {{CNT_W{1'b0}}, pop};

  assign io.io_w_ready    = in_run;
  assign io.io_r_ready    = in_run & (occ < (CNT_W+1)'(RESP_DEPTH));
  assign r_fire           = io.io_r_valid & io.io_r_ready;
  assign io.io_resp_valid = reset & (count != '0);
  assign io.io_resp_data  = fifo[rd_ptr];
  assign io_init_done     = in_run;

  assign sram_R0_en   = r_fire;
  assign sram_R0_addr = io.io_r_addr;

  always_comb begin
    sram_W0_en   = 1'b0;
    sram_W0_addr = '0;
    sram_W0_data = '0;
    sram_W0_mask = '0;
    unique case (1'b1)
      in_init: begin
        sram_W0_en   = INIT_EN;
        sram_W0_addr = init_cnt;
        sram_W0_mask = '1;
      end
      in_run: begin
        sram_W0_en   = io.io_w_valid;
        sram_W0_addr = io.io_w_addr;
        sram_W0_data = io.io_w_data;
        sram_W0_mask = io.io_w_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= r_fire;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
        if (init_last) state <= ST_RUN;
      end
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push) fifo[wr_ptr] <= sram_R0_data;
  end
endmodule

// File: tb/tb_sram_ctrl_5.sv
// tb_sram_ctrl_5: vector table plus scoreboard bench for sram_ctrl_5,
// with a behavioural masked 1R1W macro attached to the SRAM ports.
module tb_sram_ctrl_5;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_ctrl_5_if #(.ADDR_W(6), .DATA_W(24), .GROUPS(4)) bus ();

  logic        io_init_done;
  logic        sram_W0_en;
  logic [5:0]  sram_W0_addr;
  logic [23:0] sram_W0_data;
  logic [3:0]  sram_W0_mask;
  logic        sram_R0_en;
  logic [5:0]  sram_R0_addr;
  logic [23:0] sram_R0_data;

  sram_ctrl_5 #(
    .ADDR_W(6), .DATA_W(24), .GROUPS(4),
    .RESP_DEPTH(2), .INIT_EN(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(bus),
    .io_init_done(io_init_done),
    .sram_W0_en(sram_W0_en),
    .sram_W0_addr(sram_W0_addr),
    .sram_W0_data(sram_W0_data),
    .sram_W0_mask(sram_W0_mask),
    .sram_R0_en(sram_R0_en),
    .sram_R0_addr(sram_R0_addr),
    .sram_R0_data(sram_R0_data)
  );

  function automatic logic [23:0] merge(
    input logic [23:0] old, input logic [23:0] nw,
    input logic [3:0] m
  );
    logic [23:0] r;
    r = old;
    for (int g = 0; g < 4; g++)
      if (m[g]) r[g*6 +: 6] = nw[g*6 +: 6];
    return r;
  endfunction

  // Macro model: write-through on a same-address read, 1-cycle read.
  logic [23:0] macro_mem [64];
  bit          seeded = 1'b0;
  logic [23:0] w_word;
  assign w_word = merge(macro_mem[sram_W0_addr], sram_W0_data, sram_W0_mask);

  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++)
        macro_mem[i] <= 24'hA5A5A5 ^ 24'(i * 7919);
      seeded <= 1'b1;
    end else if (sram_W0_en) begin
      macro_mem[sram_W0_addr] <= w_word;
    end
    if (sram_R0_en)
      sram_R0_data <= (sram_W0_en && sram_W0_addr == sram_R0_addr)
                      ? w_word : macro_mem[sram_R0_addr];
  end

  typedef struct {
    logic        wv;
    logic [5:0]  wa;
    logic [23:0] wd;
    logic [3:0]  wm;
    logic        rv;
    logic [5:0]  ra;
    logic        x_w0en;
    logic        x_r0en;
  } vec_t;

  vec_t        vecs [12];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] ref_mem [64];
  logic [23:0] exp_q [$];
  logic        hold_v = 1'b0;
  logic [23:0] hold_d = '0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    if (!reset) begin
      hold_v = 1'b0;
      return;
    end
    if (hold_v) begin
      chk("resp_hold_valid", 32'(bus.io_resp_valid), 32'd1);
      chk("resp_hold_data", 32'(bus.io_resp_data), 32'(hold_d));
    end
    if (bus.io_w_valid && bus.io_w_ready)
      ref_mem[bus.io_w_addr] = merge(ref_mem[bus.io_w_addr],
                                     bus.io_w_data, bus.io_w_mask);
    if (bus.io_r_valid && bus.io_r_ready)
      exp_q.push_back(ref_mem[bus.io_r_addr]);
    if (bus.io_resp_valid && bus.io_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got %0h required none",
                 bus.io_resp_data);
      end else begin
        chk("resp_data", 32'(bus.io_resp_data), 32'(exp_q.pop_front()));
      end
    end
    hold_v = bus.io_resp_valid && !bus.io_resp_ready;
    hold_d = bus.io_resp_data;
  endtask

  task automatic half();
    @(negedge clock);
  endtask

  task automatic fin();
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_init_done", 32'(io_init_done), 32'd0);
    chk("rst_w_ready", 32'(bus.io_w_ready), 32'd0);
    chk("rst_r_ready", 32'(bus.io_r_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.io_resp_valid), 32'd0);
    chk("rst_w0_en", 32'(sram_W0_en), 32'd0);
    chk("rst_r0_en", 32'(sram_R0_en), 32'd0);
  endtask

  // Hold reset with requests offered; release leaves us in cycle 1.
  task automatic do_reset();
    reset = 1'b0;
    bus.io_w_valid = 1'b1;
    bus.io_r_valid = 1'b1;
    bus.io_resp_ready = 1'b1;
    exp_q.delete();
    hold_v = 1'b0;
    repeat (2) begin
      half();
      check_reset_vals();
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    bus.io_w_valid = 1'b0;
    bus.io_r_valid = 1'b0;
  endtask

  task automatic run_init(input int stop_at);
    for (int k = 1; k <= 64; k++) begin
      half();
      chk("init_done_low", 32'(io_init_done), 32'd0);
      chk("init_w_ready", 32'(bus.io_w_ready), 32'd0);
      chk("init_r_ready", 32'(bus.io_r_ready), 32'd0);
      chk("init_w0_en", 32'(sram_W0_en), 32'd1);
      chk("init_w0_addr", 32'(sram_W0_addr), 32'(k - 1));
      chk("init_w0_data", 32'(sram_W0_data), 32'd0);
      chk("init_w0_mask", 32'(sram_W0_mask), 32'hF);
      @(posedge clock);
      #1;
      if (k - 1 == stop_at) return;
    end
    half();
    chk("init_done_c65", 32'(io_init_done), 32'd1);
    chk("run_w_ready", 32'(bus.io_w_ready), 32'd1);
    chk("run_r_ready", 32'(bus.io_r_ready), 32'd1);
    chk("run_resp_empty", 32'(bus.io_resp_valid), 32'd0);
    fin();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 6'd5, 24'hABCDEF, 4'hF, 1'b0, 6'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 6'd5, 24'h000FC0, 4'h2, 1'b0, 6'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 6'd0, 24'h0,      4'h0, 1'b1, 6'd5, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 6'd1, 24'h111111, 4'hF, 1'b1, 6'd2, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 6'd2, 24'h222222, 4'hF, 1'b0, 6'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 6'd3, 24'h333333, 4'hF, 1'b1, 6'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 6'd9, 24'h123456, 4'hF, 1'b1, 6'd9, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 6'd9, 24'h654321, 4'hF, 1'b0, 6'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 6'd0, 24'h0,      4'h0, 1'b1, 6'd9, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 6'd7, 24'hFFFFFF, 4'h0, 1'b1, 6'd7, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 6'd0, 24'h0,      4'h0, 1'b0, 6'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 6'd44, 24'hC0FFEE, 4'h5, 1'b0, 6'd3, 1'b0, 1'b0};

    bus.io_w_valid = 1'b0;
    bus.io_w_addr = '0;
    bus.io_w_data = '0;
    bus.io_w_mask = '0;
    bus.io_r_valid = 1'b0;
    bus.io_r_addr = '0;
    bus.io_resp_ready = 1'b1;

    do_reset();
    run_init(-1);

    for (int a = 0; a < 64; a++) begin
      bus.io_r_valid = 1'b1;
      bus.io_r_addr = 6'(a);
      half();
      chk("rd_all_ready", 32'(bus.io_r_ready), 32'd1);
      fin();
    end
    bus.io_r_valid = 1'b0;
    drain();

    foreach (vecs[i]) begin
      bus.io_w_valid = vecs[i].wv;
      bus.io_w_addr = vecs[i].wa;
      bus.io_w_data = vecs[i].wd;
      bus.io_w_mask = vecs[i].wm;
      bus.io_r_valid = vecs[i].rv;
      bus.io_r_addr = vecs[i].ra;
      half();
      chk("vec_w_ready", 32'(bus.io_w_ready), 32'd1);
      chk("vec_r_ready", 32'(bus.io_r_ready), 32'd1);
      chk("vec_w0_en", 32'(sram_W0_en), 32'(vecs[i].x_w0en));
      chk("vec_r0_en", 32'(sram_R0_en), 32'(vecs[i].x_r0en));
      if (vecs[i].wv) begin
        chk("vec_w0_addr", 32'(sram_W0_addr), 32'(vecs[i].wa));
        chk("vec_w0_data", 32'(sram_W0_data), 32'(vecs[i].wd));
        chk("vec_w0_mask", 32'(sram_W0_mask), 32'(vecs[i].wm));
      end
      if (vecs[i].rv)
        chk("vec_r0_addr", 32'(sram_R0_addr), 32'(vecs[i].ra));
      fin();
    end
    bus.io_w_valid = 1'b0;
    bus.io_r_valid = 1'b0;
    drain();

    // Back-to-back reads: first response two cycles after accept.
    for (int c = 0; c < 6; c++) begin
      bus.io_r_valid = (c < 3);
      bus.io_r_addr = 6'(c + 1);
      half();
      if (c < 3) chk("b2b_r_ready", 32'(bus.io_r_ready), 32'd1);
      chk("b2b_resp_valid", 32'(bus.io_resp_valid),
          32'(c >= 2 && c <= 4));
      fin();
    end
    drain();

    // Back-pressure: two reads fill the FIFO, third waits for a pop.
    bus.io_resp_ready = 1'b0;
    bus.io_r_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.io_r_addr = (c < 2) ? 6'(c + 1) : 6'd3;
      half();
      chk("bp_r_ready", 32'(bus.io_r_ready), 32'(c < 2));
      if (c >= 2) chk("bp_resp_valid", 32'(bus.io_resp_valid), 32'd1);
      fin();
    end
    bus.io_resp_ready = 1'b1;
    half();
    chk("bp_pop_accept", 32'(bus.io_r_ready), 32'd1);
    fin();
    bus.io_r_valid = 1'b0;
    drain();

    // Reset during RUN with a full FIFO, then again mid-init.
    bus.io_resp_ready = 1'b0;
    bus.io_r_valid = 1'b1;
    bus.io_r_addr = 6'd5;
    tick();
    tick();
    bus.io_r_valid = 1'b0;
    tick();
    half();
    chk("pre_rst_valid", 32'(bus.io_resp_valid), 32'd1);
    fin();
    do_reset();
    run_init(30);
    do_reset();
    run_init(-1);

    bus.io_resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.io_r_valid = 1'b1;
      bus.io_r_addr = (i == 0) ? 6'd5 : (i == 1) ? 6'd9 : 6'd1;
      tick();
    end
    bus.io_r_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
